if_fetch_unit: RTL and testbench

//  Instruction-fetch stage that feeds the combinational instruction ROM.
//  - Owns the program counter and drives rom_ce / rom_addr.
//  - Registers the returned word into the IF/ID outputs.
//  - Handles stall, branch redirect (delay-slot semantics, no bubble) and flush.

---
 rtl/mips_defs.sv | 19 +
 rtl/pc_next_sel.sv | 50 +++++
 rtl/if_fetch_unit.sv | 136 +++++++++++++
 tb/tb_if_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared fetch-stage constants, state enum and PC range helper
package mips_defs;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // A fetchable PC is word aligned and inside the 4*2**addr_w byte ROM window.
  function automatic logic pc_legal(input logic [INST_W-1:0] p, input int addr_w);
    return (p[1:0] == 2'b00) && ({32'd0, p} < (64'd4 << addr_w));
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - priority mux choosing the next PC and IF/ID update actions
module pc_next_sel
  import mips_defs::*;
(
  input  logic              flush,
  input  logic [INST_W-1:0] flush_pc,
  input  logic              stall,
  input  logic              pend_valid,
  input  logic [INST_W-1:0] pend_tgt,
  input  logic              br_taken,
  input  logic [INST_W-1:0] br_target,
  input  logic [INST_W-1:0] pc,
  output logic [INST_W-1:0] next_pc,
  output logic              pc_load,
  output logic              pend_set,
  output logic              pend_clr,
  output logic              id_load,
  output logic              id_kill
);

  always_comb begin
    next_pc  = pc;
    pc_load  = 1'b0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    id_load  = 1'b0;
    id_kill  = 1'b0;
    if (flush) begin
      next_pc  = flush_pc;
      pc_load  = 1'b1;
      pend_clr = 1'b1;
      id_kill  = 1'b1;
    end else if (stall) begin
      // A branch resolved while stalled is remembered and applied on release.
      pend_set = br_taken;
    end else begin
      pc_load = 1'b1;
      id_load = 1'b1;
      if (pend_valid) begin
        next_pc  = pend_tgt;
        pend_clr = 1'b1;
      end else if (br_taken) begin
        next_pc = br_target;
      end else begin
        next_pc = pc + 32'd4;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage; optional PC range check under PC_RANGE_CHK_EN
module if_fetch_unit #(
  parameter int ADDR_W = 6,
  parameter logic [mips_defs::INST_W-1:0] RESET_PC = mips_defs::RESET_PC,
  parameter logic [mips_defs::INST_W-1:0] NOP_INST = mips_defs::NOP_INST
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [mips_defs::INST_W-1:0] flush_pc,
  input  logic                         br_taken,
  input  logic [mips_defs::INST_W-1:0] br_target,
  input  logic [mips_defs::INST_W-1:0] rom_inst,
  output logic                         rom_ce,
  output logic [ADDR_W-1:0]            rom_addr,
  output logic [mips_defs::INST_W-1:0] pc,
  output logic [mips_defs::INST_W-1:0] id_pc,
  output logic [mips_defs::INST_W-1:0] id_inst,
  output logic                         id_valid,
  output logic                         fetch_err
);

  import mips_defs::*;

  fetch_state_e      state_q, state_d;
  logic [INST_W-1:0] pc_d, id_pc_d, id_inst_d, pend_tgt, pend_tgt_d;
  logic              rom_ce_d, id_valid_d, pend_valid, pend_valid_d, err_q, err_d;

  logic [INST_W-1:0] sel_next_pc;
  logic              sel_pc_load, sel_pend_set, sel_pend_clr, sel_id_load, sel_id_kill;
  logic              next_ok;

  assign rom_addr  = pc[ADDR_W+1:2];
  assign fetch_err = err_q;

  pc_next_sel u_pc_next_sel (
    .flush     (flush),
    .flush_pc  (flush_pc),
    .stall     (stall),
    .pend_valid(pend_valid),
    .pend_tgt  (pend_tgt),
    .br_taken  (br_taken),
    .br_target (br_target),
    .pc        (pc),
    .next_pc   (sel_next_pc),
    .pc_load   (sel_pc_load),
    .pend_set  (sel_pend_set),
    .pend_clr  (sel_pend_clr),
    .id_load   (sel_id_load),
    .id_kill   (sel_id_kill)
  );

`ifdef PC_RANGE_CHK_EN
  assign next_ok = pc_legal(sel_next_pc, ADDR_W);
`else
  assign next_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc;
    id_pc_d      = id_pc;
    id_inst_d    = id_inst;
    id_valid_d   = id_valid;
    pend_valid_d = pend_valid;
    pend_tgt_d   = pend_tgt;
    err_d        = err_q;
    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (sel_pc_load && !next_ok) begin
          // Bad next PC: keep the last good PC and stop fetching.
          state_d      = HALT;
          err_d        = 1'b1;
          id_valid_d   = 1'b0;
          pend_valid_d = 1'b0;
        end else begin
          if (sel_pc_load) pc_d = sel_next_pc;
          if (sel_pend_set) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = br_target;
          end
          if (sel_pend_clr) pend_valid_d = 1'b0;
          if (sel_id_kill) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
          end
          if (sel_id_load) begin
            id_pc_d    = pc;
            id_inst_d  = rom_inst;
            id_valid_d = 1'b1;
          end
        end
      end
`ifdef PC_RANGE_CHK_EN
      HALT: begin
        if (flush && pc_legal(flush_pc, ADDR_W)) begin
          state_d      = RUN;
          pc_d         = flush_pc;
          id_valid_d   = 1'b0;
          id_inst_d    = NOP_INST;
          pend_valid_d = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    rom_ce_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc         <= RESET_PC;
      rom_ce     <= 1'b0;
      id_pc      <= '0;
      id_inst    <= NOP_INST;
      id_valid   <= 1'b0;
      pend_valid <= 1'b0;
      pend_tgt   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      rom_ce     <= rom_ce_d;
      id_pc      <= id_pc_d;
      id_inst    <= id_inst_d;
      id_valid   <= id_valid_d;
      pend_valid <= pend_valid_d;
      pend_tgt   <= pend_tgt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed and randomized bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
  logic [31:0] flush_pc = '0, br_target = '0;
  logic [31:0] rom_inst, pc, id_pc, id_inst;
  logic        rom_ce, id_valid, fetch_err;
  logic [5:0]  rom_addr;
  logic [31:0] rom_mem [64];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign rom_inst = rom_mem[rom_addr];

  if_fetch_unit #(.ADDR_W(6), .RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .br_taken(br_taken), .br_target(br_target), .rom_inst(rom_inst),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .pc(pc), .id_pc(id_pc),
    .id_inst(id_inst), .id_valid(id_valid), .fetch_err(fetch_err)
  );

  // Reference model state
  bit          m_run, m_halt, m_ce, m_id_valid, m_pend, m_err;
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_pend_tgt;

  function automatic bit legal(logic [31:0] p);
`ifdef PC_RANGE_CHK_EN
    return (p[1:0] == 2'b00) && (p < 32'h100);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_ce = 0; m_id_valid = 0; m_pend = 0; m_err = 0;
    m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0; m_pend_tgt = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] npc;
    if (!m_run && !m_halt) begin
      m_run = 1; m_ce = 1;
      return;
    end
    if (m_halt) begin
      if (flush && legal(flush_pc)) begin
        m_halt = 0; m_run = 1; m_ce = 1; m_pc = flush_pc;
        m_id_valid = 0; m_id_inst = 32'h0; m_pend = 0;
      end
      return;
    end
    if (stall && !flush) begin
      if (br_taken) begin m_pend = 1; m_pend_tgt = br_target; end
      return;
    end
    npc = flush ? flush_pc : m_pend ? m_pend_tgt : br_taken ? br_target : m_pc + 32'd4;
    if (!legal(npc)) begin
      m_halt = 1; m_run = 0; m_ce = 0; m_err = 1; m_id_valid = 0; m_pend = 0;
      return;
    end
    if (flush) begin
      m_id_valid = 0; m_id_inst = 32'h0;
    end else begin
      m_id_pc = m_pc; m_id_inst = rom_mem[m_pc[7:2]]; m_id_valid = 1;
    end
    m_pend = 0;
    m_pc = npc;
  endtask

  task automatic tick();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".rom_ce"}, {31'd0, rom_ce}, {31'd0, m_ce});
    chk({tag, ".rom_addr"}, {26'd0, rom_addr}, {26'd0, m_pc[7:2]});
    chk({tag, ".id_pc"}, id_pc, m_id_pc);
    chk({tag, ".id_inst"}, id_inst, m_id_inst);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_id_valid});
    chk({tag, ".fetch_err"}, {31'd0, fetch_err}, {31'd0, m_err});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
    rom_mem[1] = 32'h01010101;

    // Reset and release
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", {31'd0, rom_ce}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk_all("rst");
    rst_n = 1'b1;
    tick();
    chk("rel_ce", {31'd0, rom_ce}, 32'd1);
    chk("rel_pc", pc, 32'h0);
    chk_all("rel");
    tick();
    chk("pc4", pc, 32'h4);
    tick();
    chk("pc8", pc, 32'h8);
    chk("id_pc4", id_pc, 32'h4);
    chk("id_inst1", id_inst, 32'h01010101);
    chk_all("run");

    // Stall with branch
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h20;
    tick();
    br_taken = 1'b0;
    chk("stall1_pc", pc, 32'h8);
    chk("stall1_idpc", id_pc, 32'h4);
    tick();
    chk("stall2_pc", pc, 32'h8);
    chk("stall2_idinst", id_inst, 32'h01010101);
    chk_all("stall");
    stall = 1'b0;
    tick();
    chk("pend_pc", pc, 32'h20);
    chk("pend_idpc", id_pc, 32'h8);
    chk_all("pend");

    // Flush during stall
    stall = 1'b1; flush = 1'b1; flush_pc = 32'h10;
    tick();
    stall = 1'b0; flush = 1'b0;
    chk("flush_pc", pc, 32'h10);
    chk("flush_idv", {31'd0, id_valid}, 32'd0);
    chk("flush_inst", id_inst, 32'h0);
    chk_all("flush");

    // Wrap at the top of the ROM window
    flush = 1'b1; flush_pc = 32'hFC;
    tick();
    flush = 1'b0;
    chk("wrap_addr63", {26'd0, rom_addr}, 32'd63);
    tick();
`ifdef PC_RANGE_CHK_EN
    chk("wrap_err", {31'd0, fetch_err}, 32'd1);
    chk("wrap_ce", {31'd0, rom_ce}, 32'd0);
    chk("wrap_pc", pc, 32'hFC);
`else
    chk("wrap_pc", pc, 32'h100);
    chk("wrap_addr0", {26'd0, rom_addr}, 32'd0);
`endif
    chk_all("wrap");
    flush = 1'b1; flush_pc = 32'h0;
    tick();
    flush = 1'b0;

    // Misaligned branch target
    br_taken = 1'b1; br_target = 32'h22;
    tick();
    br_taken = 1'b0;
`ifdef PC_RANGE_CHK_EN
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_pc", pc, 32'h0);
`else
    chk("mis_pc", pc, 32'h22);
    chk("mis_addr", {26'd0, rom_addr}, 32'd8);
`endif
    chk_all("mis");
    flush = 1'b1; flush_pc = 32'h0;
    tick();
    flush = 1'b0;
    chk("resume_pc", pc, 32'h0);
    chk("resume_ce", {31'd0, rom_ce}, 32'd1);
    chk_all("resume");

    // Asynchronous reset between edges
    repeat (5) tick();
    chk("pre_arst_pc", pc, 32'h14);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_ce", {31'd0, rom_ce}, 32'd0);
    chk("arst_idv", {31'd0, id_valid}, 32'd0);
    model_reset();
    chk_all("arst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      br_taken = ($urandom_range(0, 6) == 0);
      br_target = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511)
                                              : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      flush_pc  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511)
                                              : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      tick();
      chk_all("rand");
    end
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
